// File: rtl/game_pkg.sv
// Shared game-level types and constants: health FSM encoding, fight-state
// code and default tuning values for the player health controller.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ALIVE  = 2'd1,
        INVULN = 2'd2,
        DEAD   = 2'd3
    } hp_state_t;

    // game_active value meaning "fight running"; anything else freezes play.
    localparam logic [1:0] GAME_FIGHT = 2'b01;

    localparam int unsigned POS_W = 12;

    localparam int unsigned DEF_MAX_HP      = 5;
    localparam int unsigned DEF_CONTACT_DMG = 1;
    localparam int unsigned DEF_PROJ_DMG    = 2;
    localparam int unsigned DEF_HEAL_AMT    = 1;
    localparam int unsigned DEF_IFRAMES     = 60;

    // Absolute difference of two screen coordinates, widened so it never wraps.
    function automatic logic [POS_W:0] abs_diff(input logic [POS_W-1:0] a,
                                                 input logic [POS_W-1:0] b);
        if (a >= b) begin
            return {1'b0, a} - {1'b0, b};
        end else begin
            return {1'b0, b} - {1'b0, a};
        end
    endfunction

endpackage

// File: rtl/box_overlap.sv
// Combinational axis-aligned box test using centre positions and full
// extents. Boxes whose edges only touch are not considered overlapping.
module box_overlap
    import game_pkg::*;
(
    input  logic [POS_W-1:0] a_x,
    input  logic [POS_W-1:0] a_y,
    input  logic [POS_W-1:0] a_w,
    input  logic [POS_W-1:0] a_h,
    input  logic [POS_W-1:0] b_x,
    input  logic [POS_W-1:0] b_y,
    input  logic [POS_W-1:0] b_w,
    input  logic [POS_W-1:0] b_h,
    output logic             hit
);

    logic [POS_W:0] dx;
    logic [POS_W:0] dy;
    logic [POS_W:0] half_w;
    logic [POS_W:0] half_h;

    // Centre distance against half the summed extents, per axis, in 13 bits.
    always_comb begin
        dx     = abs_diff(a_x, b_x);
        dy     = abs_diff(a_y, b_y);
        half_w = ({1'b0, a_w} + {1'b0, b_w}) >> 1;
        half_h = ({1'b0, a_h} + {1'b0, b_h}) >> 1;
        hit    = (dx < half_w) && (dy < half_h);
    end

endmodule

// File: rtl/char_hp_ctrl.sv
// Player health controller. Owns char_hp, evaluates body contact and
// projectile hits once per frame, applies saturating damage/heal and runs
// invulnerability frames after each hit.
//
// Pulse inputs (frame_tick, game_start, boss_hit, heal_req) are one-cycle
// strobes sampled on the rising clock edge; there is no back-pressure.
// boss_hit/heal_req are latched into sticky pending flags until the next
// active frame_tick consumes them. All outputs are registered.
module char_hp_ctrl
    import game_pkg::*;
#(
    parameter int unsigned MAX_HP      = DEF_MAX_HP,
    parameter int unsigned CONTACT_DMG = DEF_CONTACT_DMG,
    parameter int unsigned PROJ_DMG    = DEF_PROJ_DMG,
    parameter int unsigned HEAL_AMT    = DEF_HEAL_AMT,
    parameter int unsigned IFRAMES     = DEF_IFRAMES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic             game_start,
    input  logic [1:0]       game_active,
    input  logic [POS_W-1:0] char_x,
    input  logic [POS_W-1:0] char_y,
    input  logic [POS_W-1:0] char_lng,
    input  logic [POS_W-1:0] char_hgt,
    input  logic [POS_W-1:0] boss_x,
    input  logic [POS_W-1:0] boss_y,
    input  logic [POS_W-1:0] boss_lng,
    input  logic [POS_W-1:0] boss_hgt,
    input  logic             boss_hit,
    input  logic             heal_req,
    output logic [3:0]       char_hp,
    output logic             char_dead,
    output logic             invuln,
    output logic             hit_pulse,
    output hp_state_t        state_dbg
);

    hp_state_t  state, state_n;
    logic [3:0] hp_n;
    logic [7:0] iframe_cnt, iframe_cnt_n;
    logic       hit_pend, hit_pend_n;
    logic       heal_pend, heal_pend_n;
    logic       hit_pulse_n;
    logic       overlap, overlap_q;

    logic       active_tick;
    logic       eff_hit;
    logic [4:0] dmg;
    logic [4:0] hp_ext;
    logic [3:0] hp_sub;
    logic [4:0] hp_heal_sum;
    logic [3:0] hp_heal;

    box_overlap u_box_overlap (
        .a_x (char_x),
        .a_y (char_y),
        .a_w (char_lng),
        .a_h (char_hgt),
        .b_x (boss_x),
        .b_y (boss_y),
        .b_w (boss_lng),
        .b_h (boss_hgt),
        .hit (overlap)
    );

    assign state_dbg = state;

    // Damage / heal arithmetic for the current frame. A boss_hit coinciding
    // with the tick counts for it, so it is folded in alongside hit_pend.
    always_comb begin
        active_tick = frame_tick && (game_active == GAME_FIGHT);
        eff_hit     = hit_pend || boss_hit;
        dmg         = (eff_hit   ? 5'(PROJ_DMG)    : 5'd0)
                    + (overlap_q ? 5'(CONTACT_DMG) : 5'd0);
        hp_ext      = {1'b0, char_hp};
        hp_sub      = (dmg >= hp_ext) ? 4'd0 : 4'(hp_ext - dmg);
        hp_heal_sum = hp_ext + 5'(HEAL_AMT);
        hp_heal     = (hp_heal_sum > 5'(MAX_HP)) ? 4'(MAX_HP) : hp_heal_sum[3:0];
    end

    // Next-state logic for the health FSM, HP, i-frame counter and pending flags.
    always_comb begin
        state_n      = state;
        hp_n         = char_hp;
        iframe_cnt_n = iframe_cnt;
        hit_pend_n   = hit_pend || boss_hit;
        heal_pend_n  = heal_pend || heal_req;
        hit_pulse_n  = 1'b0;

        if (game_start) begin
            // Restart wins over every other event in the same cycle.
            state_n      = ALIVE;
            hp_n         = 4'(MAX_HP);
            iframe_cnt_n = 8'd0;
            hit_pend_n   = 1'b0;
            heal_pend_n  = 1'b0;
        end else if (active_tick) begin
            // Flags are consumed in every state; a heal arriving on the tick
            // itself is shadowed by consumption and kept for the next frame.
            hit_pend_n  = 1'b0;
            heal_pend_n = heal_req;
            case (state)
                ALIVE: begin
                    if (dmg != 5'd0) begin
                        hp_n        = hp_sub;
                        hit_pulse_n = 1'b1;
                        if (hp_sub == 4'd0) begin
                            state_n = DEAD;
                        end else begin
                            state_n      = INVULN;
                            iframe_cnt_n = 8'(IFRAMES);
                        end
                    end else if (heal_pend) begin
                        hp_n = hp_heal;
                    end
                end
                INVULN: begin
                    // Damage is ignored here, including on the exit tick.
                    iframe_cnt_n = iframe_cnt - 8'd1;
                    if (iframe_cnt == 8'd1) begin
                        state_n = ALIVE;
                    end
                    if (heal_pend) begin
                        hp_n = hp_heal;
                    end
                end
                DEAD: begin
                    hp_n = 4'd0;
                end
                default: begin
                    // IDLE holds HP until a game starts.
                end
            endcase
        end
    end

    // State register, registered outputs and the one-cycle overlap sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            char_hp    <= 4'd0;
            iframe_cnt <= 8'd0;
            hit_pend   <= 1'b0;
            heal_pend  <= 1'b0;
            hit_pulse  <= 1'b0;
            char_dead  <= 1'b0;
            invuln     <= 1'b0;
            overlap_q  <= 1'b0;
        end else begin
            state      <= state_n;
            char_hp    <= hp_n;
            iframe_cnt <= iframe_cnt_n;
            hit_pend   <= hit_pend_n;
            heal_pend  <= heal_pend_n;
            hit_pulse  <= hit_pulse_n;
            char_dead  <= (state_n == DEAD);
            invuln     <= (state_n == INVULN);
            overlap_q  <= overlap;
        end
    end

endmodule

// File: tb/tb_char_hp_ctrl.sv
// Bench for the player health controller: scripted frames with expected
// outputs queued at drive time and compared once the DUT has clocked.
module tb_char_hp_ctrl;
  import game_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_tick = 1'b0;
  logic        game_start = 1'b0;
  logic [1:0]  game_active = GAME_FIGHT;
  logic [11:0] char_x = 12'd100, char_y = 12'd100, char_lng = 12'd40, char_hgt = 12'd40;
  logic [11:0] boss_x = 12'd400, boss_y = 12'd100, boss_lng = 12'd40, boss_hgt = 12'd40;
  logic        boss_hit = 1'b0;
  logic        heal_req = 1'b0;
  logic [3:0]  char_hp;
  logic        char_dead;
  logic        invuln;
  logic        hit_pulse;
  hp_state_t   state_dbg;

  int          errors = 0;
  int          checks = 0;
  string       phase = "reset";
  logic [6:0]  exp_q[$];

  char_hp_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .game_start (game_start),
    .game_active(game_active),
    .char_x     (char_x),
    .char_y     (char_y),
    .char_lng   (char_lng),
    .char_hgt   (char_hgt),
    .boss_x     (boss_x),
    .boss_y     (boss_y),
    .boss_lng   (boss_lng),
    .boss_hgt   (boss_hgt),
    .boss_hit   (boss_hit),
    .heal_req   (heal_req),
    .char_hp    (char_hp),
    .char_dead  (char_dead),
    .invuln     (invuln),
    .hit_pulse  (hit_pulse),
    .state_dbg  (state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0d expected %0d", phase, tag, act, exp);
    end
  endtask

  // One clock of stimulus; expected outputs after that edge are queued first.
  task automatic do_cycle(input logic tick, input logic start, input logic hit, input logic heal,
                          input logic [3:0] e_hp, input logic e_dead, input logic e_inv,
                          input logic e_pulse);
    logic [6:0] e;
    @(negedge clk);
    frame_tick = tick;
    game_start = start;
    boss_hit   = hit;
    heal_req   = heal;
    exp_q.push_back({e_hp, e_dead, e_inv, e_pulse});
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    game_start = 1'b0;
    boss_hit   = 1'b0;
    heal_req   = 1'b0;
    e = exp_q.pop_front();
    check("char_hp",   32'(char_hp),   32'(e[6:3]));
    check("char_dead", 32'(char_dead), 32'(e[2]));
    check("invuln",    32'(invuln),    32'(e[1]));
    check("hit_pulse", 32'(hit_pulse), 32'(e[0]));
  endtask

  // Move the boss and let the overlap register settle before the next tick.
  task automatic set_boss_x(input logic [11:0] x);
    @(negedge clk);
    boss_x = x;
    repeat (2) @(posedge clk);
  endtask

  // Ticks k0..60 after a hit: invulnerable through 59, back to ALIVE on 60.
  task automatic run_iframes(input logic [3:0] hp, input int k0);
    for (int k = k0; k < 60; k++) do_cycle(1, 0, 0, 0, hp, 0, 1, 0);
    do_cycle(1, 0, 0, 0, hp, 0, 0, 0);
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("char_hp",   32'(char_hp),   32'd0);
    check("char_dead", 32'(char_dead), 32'd0);
    check("invuln",    32'(invuln),    32'd0);
    check("hit_pulse", 32'(hit_pulse), 32'd0);
    check("state",     32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    rst = 1'b1;

    phase = "start";
    do_cycle(0, 1, 0, 0, 5, 0, 0, 0);
    check("state", 32'(state_dbg), 32'(ALIVE));

    phase = "proj_hit";
    do_cycle(0, 0, 1, 0, 5, 0, 0, 0);
    do_cycle(1, 0, 0, 0, 3, 0, 1, 1);
    do_cycle(0, 0, 0, 0, 3, 0, 1, 0);
    phase = "iframes";
    for (int k = 1; k < 60; k++) do_cycle(1, 0, (k == 10), 0, 3, 0, 1, 0);
    do_cycle(1, 0, 0, 0, 3, 0, 0, 0);

    phase = "edge_touch";
    set_boss_x(12'd140);
    do_cycle(1, 0, 0, 0, 3, 0, 0, 0);
    phase = "edge_overlap";
    set_boss_x(12'd139);
    do_cycle(1, 0, 0, 0, 2, 0, 1, 1);
    set_boss_x(12'd400);
    run_iframes(2, 1);

    phase = "saturate";
    set_boss_x(12'd139);
    do_cycle(1, 0, 1, 0, 0, 1, 0, 1);
    set_boss_x(12'd400);
    phase = "dead_hold";
    do_cycle(0, 0, 0, 1, 0, 1, 0, 0);
    do_cycle(1, 0, 0, 0, 0, 1, 0, 0);
    do_cycle(1, 0, 1, 0, 0, 1, 0, 0);
    check("state", 32'(state_dbg), 32'(DEAD));

    phase = "restart_prio";
    do_cycle(1, 1, 1, 1, 5, 0, 0, 0);
    do_cycle(1, 0, 0, 0, 5, 0, 0, 0);

    phase = "heal_at_max";
    do_cycle(0, 0, 0, 1, 5, 0, 0, 0);
    do_cycle(1, 0, 0, 0, 5, 0, 0, 0);

    phase = "heal_dropped";
    do_cycle(1, 0, 1, 0, 3, 0, 1, 1);
    run_iframes(3, 1);
    do_cycle(0, 0, 0, 1, 3, 0, 0, 0);
    do_cycle(0, 0, 1, 0, 3, 0, 0, 0);
    do_cycle(1, 0, 0, 0, 1, 0, 1, 1);
    phase = "heal_invuln";
    do_cycle(0, 0, 0, 1, 1, 0, 1, 0);
    do_cycle(1, 0, 0, 0, 2, 0, 1, 0);
    do_cycle(1, 0, 0, 1, 2, 0, 1, 0);
    do_cycle(1, 0, 0, 0, 3, 0, 1, 0);
    run_iframes(3, 4);

    phase = "paused";
    game_active = 2'b10;
    do_cycle(0, 0, 1, 0, 3, 0, 0, 0);
    for (int k = 0; k < 3; k++) do_cycle(1, 0, 0, 0, 3, 0, 0, 0);
    game_active = GAME_FIGHT;
    phase = "resume";
    do_cycle(1, 0, 0, 0, 1, 0, 1, 1);
    do_cycle(1, 0, 0, 0, 1, 0, 1, 0);
    do_cycle(1, 0, 0, 0, 1, 0, 1, 0);
    phase = "counter_hold";
    game_active = 2'b00;
    for (int k = 0; k < 5; k++) do_cycle(1, 0, 0, 0, 1, 0, 1, 0);
    game_active = GAME_FIGHT;
    run_iframes(1, 3);

    phase = "async_rst";
    do_cycle(0, 1, 0, 0, 5, 0, 0, 0);
    do_cycle(1, 0, 1, 0, 3, 0, 1, 1);
    #1;
    rst = 1'b0;
    #1;
    check("char_hp",   32'(char_hp),   32'd0);
    check("char_dead", 32'(char_dead), 32'd0);
    check("invuln",    32'(invuln),    32'd0);
    check("hit_pulse", 32'(hit_pulse), 32'd0);
    check("state",     32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    rst = 1'b1;
    phase = "idle_hold";
    do_cycle(1, 0, 1, 0, 0, 0, 0, 0);

    phase = "end";
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
